serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
- Bit-serial N-bit adder built around the single-bit full-adder cell (sum = a^b^c, carry = majority(a,b,c)).
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Feeds one operand bit pair per cycle, LSB first, into the cell and holds the cell's carry in a flop between bits.
- Collects the sum bits into a result register and presents sum/cout downstream over a second valid/ready handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b/cin valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in for bit 0
- out_valid  output  1  sum/cout valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result bits, registered
- cout  output  1  carry out of MSB, registered
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset is asynchronous active-low. While rst_n=0 and after release:
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - sum=0, cout=0; carry flop, shift registers and bit counter all 0.
- Reset asserted mid-operation aborts it with no output; the operation is lost.
- State machine: IDLE, SHIFT, DONE. in_ready, out_valid and busy decode combinationally from state.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture a and b into shift registers and cin into the carry flop; clear counter and sum register; go to SHIFT.
  - in_valid=0: stay.
- SHIFT:
  - Each cycle, the cell inputs are a_sh[0], b_sh[0] and the carry flop.
  - Each edge: shift a_sh and b_sh right by 1; shift the cell sum into sum_sh at bit WIDTH-1 (sum_sh shifts right); carry flop <= cell carry; counter++.
  - On the edge where counter==WIDTH-1: load sum <= final sum_sh, cout <= cell carry; go to DONE.
  - SHIFT lasts exactly WIDTH cycles.
- DONE:
  - out_valid=1; sum and cout are stable until the handshake completes.
  - out_ready=1: go to IDLE.
  - out_ready=0: hold indefinitely.
- Latency: out_valid rises exactly WIDTH clock edges after the accepting edge.
- Minimum initiation interval is WIDTH+2 cycles: IDLE, WIDTH×SHIFT, DONE.
- in_valid during SHIFT/DONE is ignored (in_ready=0). No operand is captured; the upstream must hold.
- out_ready during IDLE/SHIFT is ignored.
- Arithmetic: {cout,sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1); no truncation is visible.
- Counter width is $clog2(WIDTH)+1 bits. WIDTH=1 means one SHIFT cycle.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset 0.
  - On the final SHIFT edge, ovf <= (carry into MSB) XOR (carry out of MSB), i.e. two's-complement signed overflow.
  - ovf is valid and held with sum while out_valid=1 and cleared on capture of a new operand.
- Not defined: no ovf port and no associated logic; all other behaviour is identical.

Test Plan:
- Reset values, WIDTH=8: with rst_n=0, in_ready=1, out_valid=0, busy=0, sum=0x00, cout=0.
- Basic add, WIDTH=8: a=0x5A, b=0x3C, cin=0 accepted at edge t.
  - out_valid=1 after edge t+8; sum=0x96, cout=0.
  - With SERIAL_ADDER_OVF_EN: ovf=1.
- Carry chain, WIDTH=8: a=0xFF, b=0x01, cin=0 gives sum=0x00, cout=1, ovf=0.
  - Then a=0xFF, b=0xFF, cin=1 gives sum=0xFF, cout=1, ovf=0.
- Backpressure, WIDTH=8: out_ready=0 for 5 cycles after out_valid rises.
  - sum, cout and out_valid stay constant throughout.
  - in_valid=1 with a=0x11 is not accepted (in_ready=0).
  - After out_ready=1, state returns to IDLE; 0x11 is accepted the next cycle and the result is correct.
- Reset mid-op, WIDTH=8: rst_n=0 pulse 3 cycles into SHIFT.
  - Outputs return to reset values immediately (async); out_valid never asserts for that op.
  - A subsequent a=0x01, b=0x02 gives sum=0x03.
- Boundary width, WIDTH=1: a=1, b=1, cin=1 gives out_valid after 1 edge, sum=1, cout=1.
  - Back-to-back ops issued at the minimum 3-cycle interval all produce correct results.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder with valid/ready operand and result handshakes
// Optional signed-overflow flag output enabled by defining SERIAL_ADDER_OVF_EN.
`timescale 1ns/1ps

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_sh;
  logic [WIDTH-1:0]   sum_sh_nxt;
  logic [WIDTH:0]     sum_cat;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               cell_s;
  logic               cell_c;
  logic               last_bit;
  logic               unused_sum_lsb;

  // Single full-adder cell fed from the operand shift register LSBs
  assign cell_s = a_sh[0] ^ b_sh[0] ^ carry;
  assign cell_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

  // New sum bit enters at the MSB; the concatenation keeps WIDTH=1 legal
  assign sum_cat        = {cell_s, sum_sh};
  assign sum_sh_nxt     = sum_cat[WIDTH:1];
  assign unused_sum_lsb = sum_cat[0];

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs decode from state only, so no input-to-output paths
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            cnt    <= '0;
            sum_sh <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
          end
        end
        S_SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_sh_nxt;
          carry  <= cell_c;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum  <= sum_sh_nxt;
            cout <= cell_c;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB on the final bit
            ovf  <= carry ^ cell_c;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
